clk_div_prog: RTL and testbench

Multi-channel, runtime-programmable clock divider that replaces the fixed single-ratio divider. Each channel derives a divided clock (`clk_out`) and a one-cycle strobe (`tick`) from the core clock. Channels have independent divisors and enables, and divisor changes take effect only at period boundaries so output transitions stay clean. Consumers are the slow peripheral/display clocks in the MIPS system; logic running in the `clk` domain uses `tick` rather than `clk_out`.

---
 rtl/clk_div_prog.sv | 169 ++++++++++++++++
 tb/tb_clk_div_prog.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// clk_div_prog -- multi-channel, runtime-programmable clock divider.
//
// Each channel divides the core clock by its own divisor D (2..2^WIDTH-1),
// producing a divided clock clk_out and a one-cycle tick at the start of
// every period. Divisor writes issued while a channel runs are held pending
// and applied only at the next period boundary, so periods never truncate.
//
// Optional feature macro: CLK_DIV_PROG_DUTY50_EN
//   When defined, each channel adds a falling-edge flop so odd divisors
//   produce a 50% duty clk_out. When undefined, odd D gives H high, H+1 low.
//
// Ports:
//   clk          in   core clock (rising edge; falling edge for duty stage)
//   reset        in   asynchronous, active-high reset
//   enable       in   [CHANNELS]        per-channel run request
//   div_wr       in   [CHANNELS]        per-channel divisor write strobe
//   div_in       in   [CHANNELS*WIDTH]  divisor values, channel i at [i*WIDTH +: WIDTH]
//   clk_out      out  [CHANNELS]        divided clocks
//   tick         out  [CHANNELS]        one-cycle pulse at the start of each period
//   div_pending  out  [CHANNELS]        a written divisor waits for the next boundary

module clk_div_prog #(
  parameter int WIDTH     = 8,
  parameter int CHANNELS  = 2,
  parameter int DIV_RESET = 12
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS-1:0]       div_wr,
  input  logic [CHANNELS*WIDTH-1:0] div_in,
  output logic [CHANNELS-1:0]       clk_out,
  output logic [CHANNELS-1:0]       tick,
  output logic [CHANNELS-1:0]       div_pending
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] d_act_q, d_act_d;
    logic [WIDTH-1:0] d_pend_q, d_pend_d;
    logic             pend_v_q, pend_v_d;
    logic             pos_q, pos_d;
    logic             tick_q, tick_d;

    logic [WIDTH-1:0] wr_val;
    logic [WIDTH-1:0] d_new;
    logic             wrap;
    logic             start;
    logic             stop;

    assign wr_val = div_in[g*WIDTH +: WIDTH];

    // Last cycle of the current period; the next edge starts a new one.
    assign wrap  = (state_q == S_RUN) && (count_q == d_act_q - WIDTH'(1));
    // Divisor governing the period that begins after this edge.
    assign d_new = (wrap && pend_v_q) ? d_pend_q : d_act_q;
    assign start = (state_q == S_IDLE) && enable[g] && (d_act_q >= WIDTH'(2));
    // Stopping is only ever decided at a wrap, so the high phase is never cut.
    assign stop  = wrap && (!enable[g] || (d_new < WIDTH'(2)));

    // State register.
    // NOTE: all sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q  <= S_IDLE;
        count_q  <= '0;
        d_act_q  <= WIDTH'(DIV_RESET);
        d_pend_q <= '0;
        pend_v_q <= 1'b0;
        pos_q    <= 1'b0;
        tick_q   <= 1'b0;
      end else begin
        state_q  <= state_d;
        count_q  <= count_d;
        d_act_q  <= d_act_d;
        d_pend_q <= d_pend_d;
        pend_v_q <= pend_v_d;
        pos_q    <= pos_d;
        tick_q   <= tick_d;
      end
    end

    // Next-state logic: state, counter and divisor bookkeeping.
    always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch.
      state_d  = state_q;
      count_d  = count_q;
      d_act_d  = d_act_q;
      d_pend_d = d_pend_q;
      pend_v_d = pend_v_q;
      unique case (state_q)
        S_IDLE: begin
          count_d = '0;
          // A value written on the stopping wrap is folded in while idle.
          if (pend_v_q) begin
            d_act_d  = d_pend_q;
            pend_v_d = 1'b0;
          end
          if (div_wr[g]) d_act_d = wr_val;
          if (start)     state_d = S_RUN;
        end
        S_RUN: begin
          count_d = wrap ? '0 : count_q + WIDTH'(1);
          if (wrap && pend_v_q) begin
            d_act_d  = d_pend_q;
            pend_v_d = 1'b0;
          end
          // A write on the wrap edge becomes pending for the following wrap.
          if (div_wr[g]) begin
            d_pend_d = wr_val;
            pend_v_d = 1'b1;
          end
          if (stop) begin
            state_d = S_IDLE;
            count_d = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Output logic: next values of the clk_out and tick flops.
    always_comb begin
      pos_d  = 1'b0;
      tick_d = 1'b0;
      unique case (state_q)
        S_IDLE: begin
          pos_d  = start;
          tick_d = start;
        end
        S_RUN: begin
          if (!stop) begin
            tick_d = wrap;
            pos_d  = (count_d < (d_new >> 1));
          end
        end
        default: ;
      endcase
    end

    assign tick[g]        = tick_q;
    assign div_pending[g] = pend_v_q;

`ifdef CLK_DIV_PROG_DUTY50_EN
    // Half-cycle stretch: extends the high phase by half a cycle; only
    // meaningful for odd divisors, so it is gated off for even ones.
    logic half_q;

    always_ff @(negedge clk or posedge reset) begin
      if (reset) half_q <= 1'b0;
      else       half_q <= pos_q;
    end

    assign clk_out[g] = pos_q | (half_q & d_act_q[0]);
`else
    assign clk_out[g] = pos_q;
`endif

  end : g_ch

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed testbench for clk_div_prog (WIDTH=8, CHANNELS=2, DIV_RESET=12).
// Outputs are sampled 1 time unit after each rising edge.

module tb_clk_div_prog;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 2;

  logic                      clk;
  logic                      reset;
  logic [CHANNELS-1:0]       enable;
  logic [CHANNELS-1:0]       div_wr;
  logic [CHANNELS*WIDTH-1:0] div_in;
  logic [CHANNELS-1:0]       clk_out;
  logic [CHANNELS-1:0]       tick;
  logic [CHANNELS-1:0]       div_pending;

  int n_total = 0;
  int n_pass  = 0;

  clk_div_prog #(
    .WIDTH     (WIDTH),
    .CHANNELS  (CHANNELS),
    .DIV_RESET (12)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .div_wr      (div_wr),
    .div_in      (div_in),
    .clk_out     (clk_out),
    .tick        (tick),
    .div_pending (div_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s @%0t: observed %0h expected %0h", tag, $time, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected clk_out sampled just after the edge that produced count c.
  function automatic logic exp_clk(input int d, input int c);
    if (d < 2) return 1'b0;
`ifdef CLK_DIV_PROG_DUTY50_EN
    if ((d % 2) == 1) return (c <= d / 2);
`endif
    return (c < d / 2);
  endfunction

  // Advance n edges. dX is channel X's divisor (0 = expected idle) and cX
  // the count it should show after the first edge.
  task automatic run2(input int d0, input int c0, input int d1, input int c1, input int n);
    int d [2];
    int c [2];
    d[0] = d0; d[1] = d1;
    c[0] = c0; c[1] = c1;
    for (int i = 0; i < n; i++) begin
      step();
      for (int ch = 0; ch < 2; ch++) begin
        check($sformatf("clk_out%0d", ch), 32'(clk_out[ch]), 32'(exp_clk(d[ch], c[ch])));
        check($sformatf("tick%0d", ch), 32'(tick[ch]), 32'((d[ch] >= 2) && (c[ch] == 0)));
        if (d[ch] >= 2) c[ch] = (c[ch] + 1) % d[ch];
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    enable = '0;
    div_wr = '0;
    div_in = '0;

    // Reset state.
    #3;
    check("rst_clk_out", 32'(clk_out), 32'h0);
    check("rst_tick", 32'(tick), 32'h0);
    check("rst_pending", 32'(div_pending), 32'h0);
    repeat (2) step();
    reset = 1'b0;
    run2(0, 0, 0, 0, 2);

    // Basic divide with the reset divisor of 12.
    enable = 2'b01;
    run2(12, 0, 0, 0, 24);
    check("basic_pending", 32'(div_pending), 32'h0);

    // Graceful disable at count 3: period completes, no tick at the wrap.
    run2(12, 0, 0, 0, 4);
    enable = 2'b00;
    run2(12, 4, 0, 0, 8);
    run2(0, 0, 0, 0, 3);

    // Re-enable restarts with an immediate tick.
    enable = 2'b01;
    run2(12, 0, 0, 0, 3);

    // Mid-period rewrite: 4 at count 2, then 6 at count 5; 4 never used.
    div_wr = 2'b01;
    div_in = {8'd0, 8'd4};
    run2(12, 3, 0, 0, 1);
    div_wr = 2'b00;
    check("rewrite_pending_a", 32'(div_pending), 32'h1);
    run2(12, 4, 0, 0, 2);
    div_wr = 2'b01;
    div_in = {8'd0, 8'd6};
    run2(12, 6, 0, 0, 1);
    div_wr = 2'b00;
    check("rewrite_pending_b", 32'(div_pending), 32'h1);
    run2(12, 7, 0, 0, 5);
    check("rewrite_pending_c", 32'(div_pending), 32'h1);
    run2(6, 0, 0, 0, 12);
    check("rewrite_pending_clr", 32'(div_pending), 32'h0);

    // Write D=0 on a wrap edge: it stops the channel at the following wrap.
    div_wr = 2'b01;
    div_in = {8'd0, 8'd0};
    run2(6, 0, 0, 0, 1);
    div_wr = 2'b00;
    check("stop_pending", 32'(div_pending), 32'h1);
    run2(6, 1, 0, 0, 5);
    run2(0, 0, 0, 0, 1);
    check("stop_pending_clr", 32'(div_pending), 32'h0);
    run2(0, 0, 0, 0, 3);
    enable = 2'b00;
    run2(0, 0, 0, 0, 1);
    enable = 2'b01;
    run2(0, 0, 0, 0, 3);

    // Odd ratio: write D=3 while idle (applies directly), then enable.
    enable = 2'b00;
    div_wr = 2'b01;
    div_in = {8'd0, 8'd3};
    run2(0, 0, 0, 0, 1);
    div_wr = 2'b00;
    check("idle_wr_pending", 32'(div_pending), 32'h0);
    enable = 2'b01;
    run2(3, 0, 0, 0, 10);

    // Asynchronous reset mid-high-phase; divisor returns to 12.
    reset = 1'b1;
    #1;
    check("async_rst_clk_out", 32'(clk_out), 32'h0);
    check("async_rst_tick", 32'(tick), 32'h0);
    #1;
    reset = 1'b0;
    run2(12, 0, 0, 0, 13);

    // Independence: ch0 D=2, ch1 D=5 enabled on the same edge.
    enable = 2'b00;
    reset  = 1'b1;
    #2;
    reset  = 1'b0;
    div_wr = 2'b11;
    div_in = {8'd5, 8'd2};
    run2(0, 0, 0, 0, 1);
    div_wr = 2'b00;
    enable = 2'b11;
    run2(2, 0, 5, 0, 10);
    div_wr = 2'b10;
    div_in = {8'd3, 8'd0};
    run2(2, 0, 5, 0, 1);
    div_wr = 2'b00;
    check("indep_pending", 32'(div_pending), 32'h2);
    run2(2, 1, 5, 1, 4);
    run2(2, 1, 3, 0, 6);
    check("indep_pending_clr", 32'(div_pending), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
